// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU memory/IO bus: FSM encoding, I/O register
// offsets and STATUS bit positions.
package mem_io_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OFS_LED    = 4'd0;
  localparam logic [3:0] OFS_SWL    = 4'd1;
  localparam logic [3:0] OFS_SWH    = 4'd2;
  localparam logic [3:0] OFS_HEX01  = 4'd3;
  localparam logic [3:0] OFS_HEX23  = 4'd4;
  localparam logic [3:0] OFS_HEX45  = 4'd5;
  localparam logic [3:0] OFS_STATUS = 4'd6;

  localparam int STS_ERR  = 0;
  localparam int STS_SLOW = 1;

endpackage

// File: rtl/mem_io_bus_ram_sp.sv
// Single-port synchronous RAM with an RD_LAT-deep read pipeline.
// Contents and pipeline are not reset; the bus only looks at o_rdata when a read completes.
module ram_sp #(
  parameter int DATA_W    = 8,
  parameter int RAM_DEPTH = 192,
  parameter int RD_LAT    = 1,
  parameter int AW        = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem  [RAM_DEPTH];
  logic [DATA_W-1:0] r_pipe [RD_LAT];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_pipe[0] <= r_mem[i_addr];
    for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end

  assign o_rdata = r_pipe[RD_LAT-1];

endmodule

// File: rtl/mem_io_bus.sv
// CPU-side memory/IO subsystem: decodes RAM, I/O registers and unmapped space,
// with a READY handshake, per-access error pulse and sticky error status.
//
// state | meaning
// IDLE  | waiting for a request with exactly one of RD/WR, or both (error)
// WAIT  | counting down the remaining RAM read latency
// DONE  | READY (and ERR if applicable) for one cycle, requests ignored
module mem_io_bus
  import mem_io_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RAM_DEPTH = 192,
  parameter int IO_BASE   = 240,
  parameter int RD_LAT    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] MADDR,
  input  logic [DATA_W-1:0] DATA_I,
  input  logic              RD,
  input  logic              WR,
  output logic [DATA_W-1:0] Q,
  output logic              READY,
  output logic              ERR,
  input  logic [9:0]        SW,
  output logic [DATA_W-1:0] LED,
  output logic [23:0]       HEX_VAL
);

  localparam int RA_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_ram_rd;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_led;
  logic [23:0]       r_hex;
  logic              r_sts_err;
  logic [9:0]        r_sw_s1;
  logic [9:0]        r_sw_s2;

  logic              w_in_ram;
  logic              w_in_io;
  logic [3:0]        w_ofs;
  logic [DATA_W-1:0] w_io_rdata;
  logic              w_io_rd_ok;
  logic              w_io_wr_ok;
  logic              w_rd;
  logic              w_wr;
  logic              w_both;
  logic              w_idle;
  logic              w_accept;
  logic              w_map_ok;
  logic              w_err;
  logic              w_ram_we;
  logic              w_ram_re;
  logic              w_io_we;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_in_ram = 32'(MADDR) < 32'(RAM_DEPTH);
  assign w_in_io  = (32'(MADDR) >= 32'(IO_BASE)) && (32'(MADDR) < 32'(IO_BASE) + 32'd16);
  assign w_ofs    = 4'(MADDR - ADDR_W'(IO_BASE));

  always_comb begin
    w_io_rdata = '0;
    w_io_rd_ok = 1'b1;
    w_io_wr_ok = 1'b0;
    case (w_ofs)
      OFS_LED:    begin w_io_rdata = r_led;                 w_io_wr_ok = 1'b1; end
      OFS_SWL:    w_io_rdata = DATA_W'(r_sw_s2[7:0]);
      OFS_SWH:    w_io_rdata = DATA_W'(r_sw_s2[9:8]);
      OFS_HEX01:  begin w_io_rdata = DATA_W'(r_hex[7:0]);   w_io_wr_ok = 1'b1; end
      OFS_HEX23:  begin w_io_rdata = DATA_W'(r_hex[15:8]);  w_io_wr_ok = 1'b1; end
      OFS_HEX45:  begin w_io_rdata = DATA_W'(r_hex[23:16]); w_io_wr_ok = 1'b1; end
      OFS_STATUS: begin
        w_io_rdata[STS_ERR]  = r_sts_err;
        w_io_rdata[STS_SLOW] = (RD_LAT > 1);
        w_io_wr_ok           = 1'b1;
      end
      default:    w_io_rd_ok = 1'b0;
    endcase
  end

  assign w_rd     = RD & ~WR;
  assign w_wr     = WR & ~RD;
  assign w_both   = RD & WR;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & (RD | WR);
  assign w_map_ok = w_in_ram | (w_in_io & (w_rd ? w_io_rd_ok : w_io_wr_ok));
  assign w_err    = w_both | ~w_map_ok;
  assign w_ram_we = w_idle & w_wr & w_in_ram;
  assign w_ram_re = w_idle & w_rd & w_in_ram;
  assign w_io_we  = w_idle & w_wr & w_in_io & w_io_wr_ok;

  ram_sp #(
    .DATA_W    (DATA_W),
    .RAM_DEPTH (RAM_DEPTH),
    .RD_LAT    (RD_LAT),
    .AW        (RA_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (RA_W'(MADDR)),
    .i_wdata (DATA_I),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_ram_rd <= 1'b0;
      r_q      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_err    <= w_err;
            r_ram_rd <= w_ram_re;
            // non-RAM reads resolve immediately; unmapped space reads as zero
            if (w_rd && !w_in_ram) r_q <= (w_in_io && w_io_rd_ok) ? w_io_rdata : '0;
            if (w_ram_re && (RD_LAT > 1)) begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_W'(RD_LAT - 2);
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_DONE: begin
          if (r_ram_rd) r_q <= w_ram_rdata;
          r_ram_rd <= 1'b0;
          r_err    <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_led     <= '0;
      r_hex     <= '0;
      r_sts_err <= 1'b0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
      if (w_io_we) begin
        case (w_ofs)
          OFS_LED:   r_led         <= DATA_I;
          OFS_HEX01: r_hex[7:0]    <= DATA_I[7:0];
          OFS_HEX23: r_hex[15:8]   <= DATA_I[7:0];
          OFS_HEX45: r_hex[23:16]  <= DATA_I[7:0];
          default:   ;
        endcase
      end
      // a new error outranks a software clear on the same edge
      if (w_accept && w_err)
        r_sts_err <= 1'b1;
      else if (w_io_we && (w_ofs == OFS_STATUS) && DATA_I[0])
        r_sts_err <= 1'b0;
    end
  end

  // RAM data is shown straight from the pipeline during DONE and latched into r_q as DONE ends
  assign READY   = (r_state == ST_DONE);
  assign ERR     = READY & r_err;
  assign Q       = (READY && r_ram_rd) ? w_ram_rdata : r_q;
  assign LED     = r_led;
  assign HEX_VAL = r_hex;

endmodule

// File: tb/tb_mem_io_bus.sv
// Scoreboard bench for mem_io_bus: one instance with RD_LAT=1, one with RD_LAT=3.
// Drivers push expected responses; per-instance monitors pop and compare on READY.
module tb_mem_io_bus;

  typedef struct {
    logic [7:0] q;
    logic       err;
    int         lat;
    bit         cq;
    int         t;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] sw  = '0;

  logic [7:0]  maddr1 = '0, din1 = '0, q1, led1;
  logic        rd1 = 1'b0, wr1 = 1'b0, ready1, err1;
  logic [23:0] hex1;
  logic [7:0]  maddr3 = '0, din3 = '0, q3, led3;
  logic        rd3 = 1'b0, wr3 = 1'b0, ready3, err3;
  logic [23:0] hex3;

  sb_t sbq1[$];
  sb_t sbq3[$];
  int  cyc     = 0;
  int  n_total = 0;
  int  n_pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_io_bus #(.ADDR_W(8), .DATA_W(8), .RAM_DEPTH(192), .IO_BASE(240), .RD_LAT(1)) dut1 (
    .CLK(clk), .RST(rst), .MADDR(maddr1), .DATA_I(din1), .RD(rd1), .WR(wr1),
    .Q(q1), .READY(ready1), .ERR(err1), .SW(sw), .LED(led1), .HEX_VAL(hex1)
  );

  mem_io_bus #(.ADDR_W(8), .DATA_W(8), .RAM_DEPTH(192), .IO_BASE(240), .RD_LAT(3)) dut3 (
    .CLK(clk), .RST(rst), .MADDR(maddr3), .DATA_I(din3), .RD(rd3), .WR(wr3),
    .Q(q3), .READY(ready3), .ERR(err3), .SW(sw), .LED(led3), .HEX_VAL(hex3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic mon(input int d, input logic [7:0] q, input logic err);
    sb_t e;
    if ((d == 0 && sbq1.size() == 0) || (d == 1 && sbq3.size() == 0)) begin
      n_total++;
      $display("FAIL unexpected_ready dut%0d: got READY=1 expected READY=0 (t=%0t)", d, $time);
      return;
    end
    if (d == 0) e = sbq1.pop_front();
    else        e = sbq3.pop_front();
    check($sformatf("latency_dut%0d", d), cyc - e.t, e.lat);
    check($sformatf("err_dut%0d", d), {31'b0, err}, {31'b0, e.err});
    if (e.cq) check($sformatf("q_dut%0d", d), {24'b0, q}, {24'b0, e.q});
  endtask

  always @(negedge clk) if (ready1) mon(0, q1, err1);
  always @(negedge clk) if (ready3) mon(1, q3, err3);

  // d: 0 selects the RD_LAT=1 instance, 1 selects the RD_LAT=3 instance
  task automatic op(input int d, input bit rd, input bit wr, input logic [7:0] a,
                    input logic [7:0] dat, input logic [7:0] eq, input bit ee,
                    input int lat, input bit cq);
    sb_t e;
    logic seen;
    e.q = eq; e.err = ee; e.lat = lat; e.cq = cq; e.t = cyc;
    if (d == 0) begin sbq1.push_back(e); maddr1 = a; din1 = dat; rd1 = rd; wr1 = wr; end
    else        begin sbq3.push_back(e); maddr3 = a; din3 = dat; rd3 = rd; wr3 = wr; end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (d == 0) ? ready1 : ready3;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL ready_timeout dut%0d addr %0h: got no READY expected READY within 20 cycles", d, a);
    end
    if (d == 0) begin rd1 = 1'b0; wr1 = 1'b0; end
    else        begin rd3 = 1'b0; wr3 = 1'b0; end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_q1", {24'b0, q1}, 32'h0);
    check("rst_ready1", {31'b0, ready1}, 32'h0);
    check("rst_err1", {31'b0, err1}, 32'h0);
    check("rst_led1", {24'b0, led1}, 32'h0);
    check("rst_hex1", {8'b0, hex1}, 32'h0);
    check("rst_q3", {24'b0, q3}, 32'h0);
    check("rst_ready3", {31'b0, ready3}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // RD_LAT=1 RAM write/read and Q hold across a write
    op(0, 0, 1, 8'd5,   8'hA5, 8'h00, 0, 1, 0);
    op(0, 1, 0, 8'd5,   8'h00, 8'hA5, 0, 1, 1);
    op(0, 0, 1, 8'd6,   8'h11, 8'h00, 0, 1, 0);
    check("q_hold_after_write", {24'b0, q1}, 32'hA5);

    // RD_LAT=3 RAM write/read, STATUS slow bit
    op(1, 0, 1, 8'd0,   8'h3C, 8'h00, 0, 1, 0);
    op(1, 1, 0, 8'd0,   8'h00, 8'h3C, 0, 3, 1);
    op(1, 1, 0, 8'd246, 8'h00, 8'h02, 0, 1, 1);

    // LED / HEX registers
    op(0, 0, 1, 8'd240, 8'h81, 8'h00, 0, 1, 0);
    op(0, 0, 1, 8'd244, 8'h7E, 8'h00, 0, 1, 0);
    check("led", {24'b0, led1}, 32'h81);
    check("hex_val", {8'b0, hex1}, 32'h007E00);
    op(0, 1, 0, 8'd244, 8'h00, 8'h7E, 0, 1, 1);

    // switches through the synchroniser
    sw = 10'h2F3;
    repeat (3) @(negedge clk);
    op(0, 1, 0, 8'd241, 8'h00, 8'hF3, 0, 1, 1);
    op(0, 1, 0, 8'd242, 8'h00, 8'h02, 0, 1, 1);

    // errors and sticky status
    op(0, 1, 1, 8'd0,   8'h99, 8'h02, 1, 1, 1);
    op(0, 1, 0, 8'd200, 8'h00, 8'h00, 1, 1, 1);
    op(0, 1, 0, 8'd246, 8'h00, 8'h01, 0, 1, 1);
    op(0, 0, 1, 8'd246, 8'h01, 8'h00, 0, 1, 0);
    op(0, 1, 0, 8'd246, 8'h00, 8'h00, 0, 1, 1);

    // region boundaries and read-only offsets
    op(0, 0, 1, 8'd241, 8'h55, 8'h00, 1, 1, 0);
    op(0, 1, 0, 8'd247, 8'h00, 8'h00, 1, 1, 1);
    op(0, 0, 1, 8'd191, 8'hC3, 8'h00, 0, 1, 0);
    op(0, 1, 0, 8'd191, 8'h00, 8'hC3, 0, 1, 1);
    op(0, 0, 1, 8'd192, 8'h77, 8'h00, 1, 1, 0);
    op(0, 1, 0, 8'd239, 8'h00, 8'h00, 1, 1, 1);
    op(0, 1, 0, 8'd246, 8'h00, 8'h01, 0, 1, 1);
    check("led_after_errors", {24'b0, led1}, 32'h81);

    // reset during WAIT of an RD_LAT=3 read
    op(1, 0, 1, 8'd9,   8'h5A, 8'h00, 0, 1, 0);
    maddr3 = 8'd9; rd3 = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1; rd3 = 1'b0;
    #1;
    check("midrst_ready3", {31'b0, ready3}, 32'h0);
    check("midrst_q3", {24'b0, q3}, 32'h0);
    check("midrst_err3", {31'b0, err3}, 32'h0);
    check("midrst_led1", {24'b0, led1}, 32'h0);
    check("midrst_hex1", {8'b0, hex1}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ready", {31'b0, ready3}, 32'h0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("postrst_no_ready", {31'b0, ready3}, 32'h0);
    op(1, 1, 0, 8'd9,   8'h00, 8'h5A, 0, 3, 1);
    op(1, 1, 0, 8'd246, 8'h00, 8'h02, 0, 1, 1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq1.size() + sbq3.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_io_bus.md
Name: mem_io_bus

Overview:
- Parametrised memory/IO subsystem between the CPU core and board I/O. It replaces the bare RAM hookup used so far.
- Decodes the CPU address bus into three regions: synchronous RAM, memory-mapped LED/HEX/switch/status registers, and unmapped space.
- Adds a READY handshake with configurable RAM read latency, and error detection with a sticky status flag.

Parameters:
- ADDR_W, 8: address width.
- DATA_W, 8: data width; must be 8 or more.
- RAM_DEPTH, 192: RAM occupies addresses 0..RAM_DEPTH-1; must be no greater than IO_BASE.
- IO_BASE, 240: first I/O register address; I/O window is IO_BASE..IO_BASE+15.
- RD_LAT, 1: RAM read latency in cycles; must be 1 or more.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- MADDR  in  ADDR_W  CPU address.
- DATA_I  in  DATA_W  CPU write data.
- RD  in  1  read request.
- WR  in  1  write request.
- Q  out  DATA_W  read data.
- READY  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle error pulse, coincident with READY.
- SW  in  10  raw board switches (asynchronous).
- LED  out  DATA_W  LED register.
- HEX_VAL  out  24  six 4-bit nibbles; digit n is HEX_VAL[4n+3:4n]; seven-segment decode happens outside this block.

Behaviour:
- Reset: FSM goes to IDLE. READY=0, ERR=0, Q=0, LED=0, HEX_VAL=0, STATUS=0, switch synchroniser cleared. RAM contents are not reset.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: samples RD/WR on each edge; a request is accepted when exactly one of them is high.
  - WAIT: counts down the RAM read latency.
  - DONE: READY=1 for exactly one cycle, then always returns to IDLE. Requests present during DONE are ignored, giving a one-cycle turnaround.
- CPU protocol: the CPU holds MADDR/DATA_I/RD/WR stable until it sees READY.
- Writes (any region): commit on the acceptance edge. READY is high in the following cycle; latency 1.
- I/O reads and unmapped reads: latency 1.
- RAM reads: go to WAIT when RD_LAT>1. READY is high RD_LAT cycles after acceptance.
- Q updates only on read completion and holds its value until the next read completes. Writes never change Q.
- RD and WR both high in IDLE:
  - no access is performed; go to DONE;
  - READY=1, ERR=1, Q unchanged, STATUS[0] set.
- Unmapped address (RAM_DEPTH..IO_BASE-1, or an undefined I/O offset):
  - read returns Q=0; write is dropped;
  - ERR=1 with READY; STATUS[0] set.
- I/O map (offset from IO_BASE):
  - +0 LED, read/write.
  - +1 SW[7:0], read-only.
  - +2 SW[9:8] zero-extended, read-only.
  - +3 HEX1:HEX0, read/write.
  - +4 HEX3:HEX2, read/write.
  - +5 HEX5:HEX4, read/write.
  - +6 STATUS, read-only, except that writing 1 to bit0 clears it. Bit0 is the sticky error flag. Bit1 reads as 1 when RD_LAT>1. Other bits read 0.
  - Writes to read-only offsets +1 and +2 are dropped with ERR.
- HEX registers: only the low 8 bits of DATA_I are used; upper bits are ignored and read back as 0.
- SW path: two-flop synchroniser. An I/O read returns the synchronised value.
- Priority: if an error occurs on the same edge as a STATUS clear, the set wins.
- Address wrap: none; the full ADDR_W space is decoded.
- Reset mid-transaction: the transaction is aborted and no READY is produced. A write already committed at its acceptance edge persists in RAM.

Decomposition:
- Package mem_io_pkg holds:
  - state encoding (IDLE/WAIT/DONE);
  - I/O offset constants (OFS_LED, OFS_SWL, OFS_SWH, OFS_HEX01, OFS_HEX23, OFS_HEX45, OFS_STATUS);
  - STATUS bit indices.
- Sub-module ram_sp: synchronous single-port RAM, DATA_W x RAM_DEPTH, with an RD_LAT-stage output pipeline. Instantiated once.

Test Plan:
- Reset, WR addr 5 data 8'hA5, then RD addr 5 with RD_LAT=1 → READY one cycle after each acceptance; Q=8'hA5; ERR=0.
- RD_LAT=3: write addr 0 data 8'h3C, then RD addr 0 → READY exactly 3 cycles after acceptance; Q=8'h3C; READY low in between; STATUS bit1=1.
- WR IO_BASE+0 data 8'h81, then WR IO_BASE+4 data 8'h7E → LED=8'h81; HEX_VAL[15:8]=8'h7E; other nibbles 0.
- SW=10'h2F3, wait 3 cycles, RD IO_BASE+1 then IO_BASE+2 → Q=8'hF3, then Q=8'h02.
- RD+WR together at addr 0, then RD addr 200 (unmapped), then RD IO_BASE+6 → ERR pulses twice; second read returns Q=0; STATUS read gives bit0=1; WR IO_BASE+6 data 1 clears it (reads 0 afterwards).
- Assert RST during WAIT of an RD_LAT=3 read → no READY; all outputs 0; RAM data written before reset still reads back correctly afterwards.
